// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 4;
  localparam int SETS_DEF       = 64;

  localparam int OFF_W = $clog2(LINE_WORDS_DEF);
  localparam int IDX_W = $clog2(SETS_DEF);
  localparam int TAG_W = ADDR_W_DEF - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational lookup, synchronous word/tag writes and valid clear.
module icache_array
  import icache_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int SETS       = SETS_DEF,
  parameter int TAG_BITS   = TAG_W,
  localparam int OFF_BITS  = $clog2(LINE_WORDS),
  localparam int IDX_BITS  = $clog2(SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [OFF_BITS-1:0] rd_off,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [DATA_W-1:0]   rd_data,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [OFF_BITS-1:0] wr_off,
  input  logic                word_we,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                tag_we,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic                clr
);

  logic                valid_reg [SETS];
  logic [TAG_BITS-1:0] tag_reg   [SETS];
  logic [DATA_W-1:0]   data_reg  [SETS][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) valid_reg[s] <= 1'b0;
    end else if (tag_we) begin
      valid_reg[wr_idx] <= 1'b1;
    end else if (clr) begin
      valid_reg[wr_idx] <= 1'b0;
    end
  end

  // Tag and data need no reset: a line is only visible once its valid bit is set.
  always_ff @(posedge clk) begin
    if (tag_we) tag_reg[wr_idx] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (word_we) data_reg[wr_idx][wr_off] <= wr_data;
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_tag   = tag_reg[rd_idx];
  assign rd_data  = data_reg[rd_idx][rd_off];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: same-cycle hits, word-by-word line refill on miss.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int SETS       = SETS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_if_i,
  input  logic              req_if_i,
  input  logic              fc_jump_flag_Icache_i,
  output logic [DATA_W-1:0] ic_inst_o,
  output logic              ic_inst_valid_o,
  output logic              ic_miss_o,
  output logic              ic_mem_req_o,
  output logic [ADDR_W-1:0] ic_mem_addr_o,
  input  logic              mem_ic_ack_i,
  input  logic [DATA_W-1:0] mem_ic_data_i
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = ADDR_W - 2 - OFF_BITS - IDX_BITS;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

  state_t              state_reg;
  logic [OFF_BITS-1:0] beat_reg;
  logic [ADDR_W-1:0]   base_reg;

  logic [OFF_BITS-1:0] pc_off;
  logic [IDX_BITS-1:0] pc_idx, base_idx;
  logic [TAG_BITS-1:0] pc_tag, base_tag;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [DATA_W-1:0]   rd_data;
  logic                in_idle, in_refill, hit, miss_start;

  assign pc_off   = pc_if_i[2 +: OFF_BITS];
  assign pc_idx   = pc_if_i[2 + OFF_BITS +: IDX_BITS];
  assign pc_tag   = pc_if_i[ADDR_W-1 -: TAG_BITS];
  assign base_idx = base_reg[2 + OFF_BITS +: IDX_BITS];
  assign base_tag = base_reg[ADDR_W-1 -: TAG_BITS];

  assign in_idle    = (state_reg == IDLE);
  assign in_refill  = (state_reg == REFILL);
  assign hit        = req_if_i & rd_valid & (rd_tag == pc_tag) & in_idle;
  assign miss_start = in_idle & req_if_i & ~hit & ~fc_jump_flag_Icache_i;

  assign ic_inst_o       = rd_data;
  assign ic_inst_valid_o = hit & ~fc_jump_flag_Icache_i;
  // Combinational so the flow controller stalls in the very cycle the miss is seen.
  assign ic_miss_o       = ~in_idle | miss_start;
  assign ic_mem_req_o    = in_refill;
  assign ic_mem_addr_o   = in_refill ? (base_reg | (ADDR_W'(beat_reg) << 2)) : '0;

  icache_array #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_idx),
    .rd_off   (pc_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_idx   (in_idle ? pc_idx : base_idx),
    .wr_off   (beat_reg),
    .word_we  (in_refill & mem_ic_ack_i),
    .wr_data  (mem_ic_data_i),
    .tag_we   (state_reg == UPDATE),
    .wr_tag   (base_tag),
    .clr      (miss_start)
  );

  // A redirect during REFILL/UPDATE does not abort the burst; the line is always installed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      base_reg  <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (miss_start) begin
            base_reg  <= pc_if_i & LINE_MASK;
            beat_reg  <= '0;
            state_reg <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ic_ack_i) begin
            beat_reg <= beat_reg + OFF_BITS'(1);
            if (beat_reg == OFF_BITS'(LINE_WORDS - 1)) state_reg <= UPDATE;
          end
        end
        UPDATE:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
